// File: rtl/ehgu_stream_seq_checker.sv
// Arithmetic-sequence checker for the read side of ehgu_fifo: counts matching and
// mismatching beats, relocks after a run of mismatches. Optional checks: EHGU_SEQ_CHECK_ASSERT_EN.
module ehgu_stream_seq_checker #(
    parameter int WIDTH         = 8,
    parameter int STEP          = 3,
    parameter int CNT_WIDTH     = 16,
    parameter int RELOCK_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 din_valid,
    input  logic [WIDTH-1:0]     din,
    output logic                 locked,
    output logic [CNT_WIDTH-1:0] pass_cnt,
    output logic [CNT_WIDTH-1:0] fail_cnt,
    output logic                 err_sticky,
    output logic [WIDTH-1:0]     exp_data
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [7:0]       THRESH_W = 8'(RELOCK_THRESH);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == {CNT_WIDTH{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    logic [1:0]           state_r,  state_s;
    logic                 locked_r, locked_s;
    logic [CNT_WIDTH-1:0] pass_r,   pass_s;
    logic [CNT_WIDTH-1:0] fail_r,   fail_s;
    logic                 err_r,    err_s;
    logic [WIDTH-1:0]     exp_r,    exp_s;
    logic [7:0]           run_r,    run_s;
    logic [7:0]           run_inc_s;
    logic                 mism_s;
    logic                 relock_s;

    // Next-state and datapath update; clr is applied last so it overrides any count.
    always_comb begin
        state_s   = state_r;
        locked_s  = locked_r;
        pass_s    = pass_r;
        fail_s    = fail_r;
        err_s     = err_r;
        exp_s     = exp_r;
        run_s     = run_r;
        run_inc_s = run_r + 8'd1;
        mism_s    = 1'b0;
        relock_s  = 1'b0;
        if (!en) begin
            state_s  = ST_IDLE;
            locked_s = 1'b0;
            run_s    = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_ACQUIRE;
                    run_s   = 8'd0;
                end
                ST_ACQUIRE: begin
                    if (din_valid) begin
                        exp_s    = din + STEP_W;
                        locked_s = 1'b1;
                        state_s  = ST_CHECK;
                        run_s    = 8'd0;
                    end else begin
                        state_s = ST_ACQUIRE;
                    end
                end
                ST_CHECK: begin
                    if (din_valid) begin
                        exp_s = din + STEP_W;
                        if (din == exp_r) begin
                            pass_s = sat_inc(pass_r);
                            run_s  = 8'd0;
                        end else begin
                            mism_s = 1'b1;
                            fail_s = sat_inc(fail_r);
                            err_s  = 1'b1;
                            // Run counter is cleared on the state exit it triggers.
                            if (run_inc_s >= THRESH_W) begin
                                relock_s = 1'b1;
                                state_s  = ST_ACQUIRE;
                                locked_s = 1'b0;
                                run_s    = 8'd0;
                            end else begin
                                run_s = run_inc_s;
                            end
                        end
                    end else begin
                        state_s = ST_CHECK;
                    end
                end
                default: begin
                    state_s  = ST_IDLE;
                    locked_s = 1'b0;
                    run_s    = 8'd0;
                end
            endcase
        end
        if (clr) begin
            pass_s = {CNT_WIDTH{1'b0}};
            fail_s = {CNT_WIDTH{1'b0}};
            err_s  = 1'b0;
        end else begin
            err_s = err_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            locked_r <= 1'b0;
            pass_r   <= {CNT_WIDTH{1'b0}};
            fail_r   <= {CNT_WIDTH{1'b0}};
            err_r    <= 1'b0;
            exp_r    <= {WIDTH{1'b0}};
            run_r    <= 8'd0;
        end else begin
            state_r  <= state_s;
            locked_r <= locked_s;
            pass_r   <= pass_s;
            fail_r   <= fail_s;
            err_r    <= err_s;
            exp_r    <= exp_s;
            run_r    <= run_s;
        end
    end

    assign locked     = locked_r;
    assign pass_cnt   = pass_r;
    assign fail_cnt   = fail_r;
    assign err_sticky = err_r;
    assign exp_data   = exp_r;

`ifdef EHGU_SEQ_CHECK_ASSERT_EN
    ehgu_stream_seq_checker_sva #(.WIDTH(WIDTH)) u_sva (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din_valid (din_valid),
        .count_mis (mism_s & ~clr),
        .relock    (relock_s),
        .din       (din),
        .exp_data  (exp_r)
    );
`else
    logic unused_s;
    assign unused_s = mism_s & relock_s;
`endif

endmodule

`ifdef EHGU_SEQ_CHECK_ASSERT_EN
// Simulation-only checks for the sequence checker.
module ehgu_stream_seq_checker_sva #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    input logic             en,
    input logic             din_valid,
    input logic             count_mis,
    input logic             relock,
    input logic [WIDTH-1:0] din,
    input logic [WIDTH-1:0] exp_data
);

    // Report counted mismatches and relocks.
    always @(posedge clk) begin
        if (!rst && count_mis) begin
            $error("seq mismatch: din=%0h exp_data=%0h", din, exp_data);
        end
        if (!rst && relock) begin
            $warning("seq checker relock");
        end
    end

    a_din_known: assert property (@(posedge clk) disable iff (rst)
        (en && din_valid) |-> !$isunknown(din));

endmodule
`endif

// File: doc/ehgu_stream_seq_checker.md
# ehgu_stream_seq_checker

Single-clock stream consumer placed on the read side of `ehgu_fifo`. It takes the FIFO's `dout`/`dout_valid` beats and checks that consecutive valid words follow an arithmetic sequence with a fixed step. It keeps saturating pass and fail counters, a sticky error flag and a lock indicator, so on-chip and emulation builds can self-check FIFO integrity across clock domains.

## Interface
Parameters:
- `WIDTH`, 8, data width; matches the FIFO `WIDTH`.
- `STEP`, 3, expected increment between consecutive valid beats, taken modulo 2^WIDTH.
- `CNT_WIDTH`, 16, width of the pass and fail counters.
- `RELOCK_THRESH`, 4, number of consecutive mismatches that forces re-acquisition; legal range 1..255.

Ports:
- `clk`  in  1  clock; the FIFO read clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  checker enable.
- `clr`  in  1  synchronous clear of the counters and the sticky flag.
- `din_valid`  in  1  beat qualifier; driven from FIFO `dout_valid`.
- `din`  in  WIDTH  beat data; driven from FIFO `dout`.
- `locked`  out  1  the checker holds a valid expected value.
- `pass_cnt`  out  CNT_WIDTH  count of matching beats.
- `fail_cnt`  out  CNT_WIDTH  count of mismatching beats.
- `err_sticky`  out  1  set by any mismatch; cleared only by `rst` or `clr`.
- `exp_data`  out  WIDTH  current expected value.

## Operation
- There is no backpressure. Every cycle with `din_valid`=1 is one beat.
- States are IDLE, ACQUIRE and CHECK. The state register is internal.
- IDLE:
  - `locked`=0.
  - Beats are ignored.
  - `en`=1 moves to ACQUIRE on the next cycle. A beat in that same cycle is ignored.
- ACQUIRE:
  - The first beat loads `exp_data` <= `din`+STEP, sets `locked`=1 and moves to CHECK.
  - That beat is not counted.
- CHECK, on each beat:
  - Match (`din`==`exp_data`): `pass_cnt`+1, mismatch run reset to 0.
  - Mismatch: `fail_cnt`+1, `err_sticky`<=1, mismatch run +1.
  - In both cases `exp_data` <= `din`+STEP. The checker resyncs to the received data, so one dropped word costs exactly one fail.
  - When the mismatch run reaches RELOCK_THRESH, go to ACQUIRE and set `locked`=0 on the same edge.
- `en`=0 in any state: go to IDLE and set `locked`=0. Counters, `err_sticky` and `exp_data` hold their values.
- Arithmetic rules:
  - `exp_data` wraps modulo 2^WIDTH.
  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - The mismatch run counter is 8 bits and is cleared on every match and on every state exit.
- `clr`:
  - Zeroes `pass_cnt`, `fail_cnt` and `err_sticky`.
  - If it coincides with a beat, `clr` wins and that beat is not counted.
  - It does not change the state, `locked`, `exp_data` or the mismatch run.

## Timing
- All outputs are registered. A beat sampled at edge N is reflected in the outputs after edge N.
- Reset values: state IDLE, `locked`=0, `pass_cnt`=0, `fail_cnt`=0, `err_sticky`=0, `exp_data`=0, mismatch run 0.
- `rst` asserted mid-stream takes effect at the next edge and overrides `en`, `clr` and the beat in that cycle.
- IDLE to ACQUIRE takes 1 cycle after `en` rises. ACQUIRE to CHECK happens on the first beat.
- Relock: `locked` falls on the edge that samples the RELOCK_THRESH-th consecutive mismatch. The fail count includes that beat.

## Configuration
- `EHGU_SEQ_CHECK_ASSERT_EN` defined:
  - A simulation-only `$error` on each counted mismatch, printing `din` and `exp_data`.
  - A `$warning` on each relock.
  - A concurrent check that `din` carries no X or Z while `din_valid`=1 and the checker is enabled.
- Undefined: no checks are emitted. The synthesizable behaviour is identical in both cases.

## Test plan
- Reset: hold `rst` for 3 cycles with `en`=1 and beats present -> every output is 0 and the state stays IDLE until 1 cycle after release.
- Clean stream: `en`=1, beats 0,3,6,…,30 (11 beats) -> `locked`=1 after the first beat; final `pass_cnt`=10, `fail_cnt`=0, `err_sticky`=0, `exp_data`=0x21.
- Wrap-around: beats 0xFA, 0xFD, 0x00, 0x03 -> `pass_cnt`=3, `fail_cnt`=0, `exp_data`=0x06.
- Dropped word: beats 0,3,9,12 -> `pass_cnt`=2, `fail_cnt`=1, `err_sticky`=1, `locked` stays 1.
- Relock: beats 0,3, then 0x50,0x60,0x70,0x80, then 0x90,0x93 -> `fail_cnt`=4 and `locked`=0 after 0x80; 0x90 re-acquires without being counted; 0x93 passes, so final `pass_cnt`=2.
- Clear and saturation: with `CNT_WIDTH`=4, send 20 matching beats -> `pass_cnt`=15. Then assert `clr` together with a matching beat -> `pass_cnt`=0 next cycle and `locked` stays 1.
